// File: rtl/layer_loader_if.sv
// Host beat stream plus IFM/WGT dpram write port for layer_loader.
// master = host/RAM side, slave = loader.
interface layer_loader_if #(
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned INOUT_WIDTH = 256,
    parameter int unsigned ADDR_WIDTH  = 24
);
    localparam int unsigned LANES = INOUT_WIDTH / DATA_WIDTH;

    logic                   s_valid;
    logic [INOUT_WIDTH-1:0] s_data;
    logic                   s_last;
    logic                   s_ready;
    logic                   ifm_we;
    logic                   wgt_we;
    logic [ADDR_WIDTH-1:0]  wr_addr;
    logic [INOUT_WIDTH-1:0] wr_data;
    logic [LANES-1:0]       wr_mask;

    modport master (
        output s_valid, s_data, s_last,
        input  s_ready, ifm_we, wgt_we, wr_addr, wr_data, wr_mask
    );

    modport slave (
        input  s_valid, s_data, s_last,
        output s_ready, ifm_we, wgt_we, wr_addr, wr_data, wr_mask
    );
endinterface

// File: rtl/layer_loader.sv
// Streams IFM then weight data from the host bus into the IFM/WGT dprams, then pulses start.
// Optional per-region checksums: define LAYER_LOADER_CHECKSUM_EN.
module layer_loader #(
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned INOUT_WIDTH = 256,
    parameter int unsigned ADDR_WIDTH  = 24
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_req,
    input  logic [8:0]  ifm_size,
    input  logic [10:0] ifm_channel,
    input  logic [1:0]  kernel_size,
    input  logic [10:0] num_filter,
    layer_loader_if.slave bus,
    output logic        busy,
    output logic        start,
`ifdef LAYER_LOADER_CHECKSUM_EN
    output logic [15:0] ifm_checksum,
    output logic [15:0] wgt_checksum,
`endif
    output logic        err_last
);
    localparam int unsigned LANES = INOUT_WIDTH / DATA_WIDTH;

    localparam logic [2:0] StIdle    = 3'd0;
    localparam logic [2:0] StCalc    = 3'd1;
    localparam logic [2:0] StLoadIfm = 3'd2;
    localparam logic [2:0] StLoadWgt = 3'd3;
    localparam logic [2:0] StDone    = 3'd4;

    logic [2:0]             state_q, state_d;
    logic [31:0]            ifm_total_q, wgt_total_q;
    logic [ADDR_WIDTH-1:0]  elem_q;
    logic                   drain_q;
    logic                   err_last_q;
    logic                   ifm_we_q, wgt_we_q;
    logic [ADDR_WIDTH-1:0]  wr_addr_q;
    logic [INOUT_WIDTH-1:0] wr_data_q;
    logic [LANES-1:0]       wr_mask_q;

    logic [31:0]            ifm_total_c, wgt_total_c;
    logic [31:0]            region_total, remaining;
    logic                   loading, accept, final_beat, in_wgt;
    logic [LANES-1:0]       beat_mask;

    assign ifm_total_c = 32'(ifm_size) * 32'(ifm_size) * 32'(ifm_channel);
    assign wgt_total_c = 32'(kernel_size) * 32'(kernel_size) * 32'(ifm_channel)
                       * 32'(num_filter);

    // drain_q holds off the bus for one cycle after the last weight beat so that
    // start follows the final RAM write instead of coinciding with it.
    assign in_wgt       = (state_q == StLoadWgt);
    assign loading      = (state_q == StLoadIfm) || (in_wgt && !drain_q);
    assign accept       = bus.s_valid && loading;
    assign region_total = in_wgt ? wgt_total_q : ifm_total_q;
    assign remaining    = region_total - 32'(elem_q);
    assign final_beat   = (remaining <= 32'(LANES));

    always_comb begin
        beat_mask = '0;
        for (int unsigned k = 0; k < LANES; k++) begin
            beat_mask[k] = (remaining > 32'(k));
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:    if (load_req) state_d = StCalc;
            StCalc: begin
                if (ifm_total_c != 32'd0)      state_d = StLoadIfm;
                else if (wgt_total_c != 32'd0) state_d = StLoadWgt;
                else                           state_d = StDone;
            end
            StLoadIfm: if (accept && final_beat) state_d = StLoadWgt;
            StLoadWgt: if (drain_q) state_d = StDone;
            StDone:    state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            ifm_total_q <= '0;
            wgt_total_q <= '0;
            elem_q      <= '0;
            drain_q     <= 1'b0;
            err_last_q  <= 1'b0;
            ifm_we_q    <= 1'b0;
            wgt_we_q    <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            wr_mask_q   <= '0;
        end else begin
            state_q   <= state_d;
            ifm_we_q  <= accept && (state_q == StLoadIfm);
            wgt_we_q  <= accept && in_wgt;
            wr_addr_q <= accept ? elem_q : '0;
            wr_data_q <= accept ? bus.s_data : '0;
            wr_mask_q <= accept ? beat_mask : '0;

            if (state_q == StIdle && load_req) err_last_q <= 1'b0;

            if (state_q == StCalc) begin
                ifm_total_q <= ifm_total_c;
                wgt_total_q <= wgt_total_c;
                elem_q      <= '0;
                drain_q     <= 1'b0;
            end

            if (accept) begin
                if (final_beat) begin
                    elem_q <= '0;
                    // An empty weight region drains straight through to DONE.
                    if (in_wgt || wgt_total_q == 32'd0) drain_q <= 1'b1;
                end else begin
                    elem_q <= elem_q + ADDR_WIDTH'(LANES);
                end
                if (bus.s_last != (in_wgt && final_beat)) err_last_q <= 1'b1;
            end
        end
    end

`ifdef LAYER_LOADER_CHECKSUM_EN
    logic [15:0] beat_sum;
    logic [15:0] ifm_sum_q, wgt_sum_q;

    always_comb begin
        beat_sum = '0;
        for (int unsigned k = 0; k < LANES; k++) begin
            if (beat_mask[k]) beat_sum = beat_sum + bus.s_data[k*DATA_WIDTH +: 16];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ifm_sum_q <= '0;
            wgt_sum_q <= '0;
        end else if (state_q == StCalc) begin
            ifm_sum_q <= '0;
            wgt_sum_q <= '0;
        end else if (accept) begin
            if (in_wgt) wgt_sum_q <= wgt_sum_q + beat_sum;
            else        ifm_sum_q <= ifm_sum_q + beat_sum;
        end
    end

    assign ifm_checksum = ifm_sum_q;
    assign wgt_checksum = wgt_sum_q;
`endif

    assign bus.s_ready = loading;
    assign bus.ifm_we  = ifm_we_q;
    assign bus.wgt_we  = wgt_we_q;
    assign bus.wr_addr = wr_addr_q;
    assign bus.wr_data = wr_data_q;
    assign bus.wr_mask = wr_mask_q;
    assign busy        = (state_q != StIdle);
    assign start       = (state_q == StDone);
    assign err_last    = err_last_q;
endmodule

// File: tb/tb_layer_loader.sv
// Directed bench for layer_loader: streams known data, mirrors writes into RAM models
// and checks write sequence, handshake timing, s_last errors and mid-load reset.
module tb_layer_loader;
    localparam int unsigned DW = 16;
    localparam int unsigned IW = 256;
    localparam int unsigned AW = 24;
    localparam int unsigned MEM = 8192;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load_req = 1'b0;
    logic [8:0]  ifm_size = '0;
    logic [10:0] ifm_channel = '0;
    logic [1:0]  kernel_size = '0;
    logic [10:0] num_filter = '0;
    logic        busy, start, err_last;
`ifdef LAYER_LOADER_CHECKSUM_EN
    logic [15:0] ifm_checksum, wgt_checksum;
`endif

    int checks = 0;
    int failures = 0;

    layer_loader_if #(.DATA_WIDTH(DW), .INOUT_WIDTH(IW), .ADDR_WIDTH(AW)) bus ();

    layer_loader #(.DATA_WIDTH(DW), .INOUT_WIDTH(IW), .ADDR_WIDTH(AW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_req    (load_req),
        .ifm_size    (ifm_size),
        .ifm_channel (ifm_channel),
        .kernel_size (kernel_size),
        .num_filter  (num_filter),
        .bus         (bus),
        .busy        (busy),
        .start       (start),
`ifdef LAYER_LOADER_CHECKSUM_EN
        .ifm_checksum(ifm_checksum),
        .wgt_checksum(wgt_checksum),
`endif
        .err_last    (err_last)
    );

    always #5 clk = ~clk;

    // Monitor state, cleared whenever an idle load_req is seen.
    int cyc = 0, req_cyc = 0, rdy_cyc = -1, ifm_wr = 0, wgt_wr = 0, stray = 0;
    int start_cnt = 0, start_cyc = 0, last_acc_cyc = 0, slast_cyc = -1, err_cyc = -1;
    logic [31:0] ifm_la = '0, ifm_lm = '0, wgt_la = '0, wgt_lm = '0;
    bit acc_prev = 1'b0;
    logic [15:0] ifm_mem [MEM];
    logic [15:0] wgt_mem [MEM];

    always @(negedge clk) begin
        bit acc;
        cyc++;
        if (load_req && !busy) begin
            req_cyc = cyc; rdy_cyc = -1; ifm_wr = 0; wgt_wr = 0; stray = 0;
            start_cnt = 0; slast_cyc = -1; err_cyc = -1;
            for (int i = 0; i < MEM; i++) begin
                ifm_mem[i] = 16'h0; wgt_mem[i] = 16'h0;
            end
        end
        if (bus.s_ready && rdy_cyc < 0) rdy_cyc = cyc;
        if ((bus.ifm_we || bus.wgt_we) != acc_prev) stray++;
        if (bus.ifm_we || bus.wgt_we) begin
            for (int k = 0; k < 16; k++) begin
                if (bus.wr_mask[k] && (int'(bus.wr_addr) + k) < MEM) begin
                    if (bus.ifm_we) ifm_mem[int'(bus.wr_addr) + k] = bus.wr_data[k*16 +: 16];
                    else            wgt_mem[int'(bus.wr_addr) + k] = bus.wr_data[k*16 +: 16];
                end
            end
        end
        if (bus.ifm_we) begin ifm_wr++; ifm_la = 32'(bus.wr_addr); ifm_lm = 32'(bus.wr_mask); end
        if (bus.wgt_we) begin wgt_wr++; wgt_la = 32'(bus.wr_addr); wgt_lm = 32'(bus.wr_mask); end
        if (start) begin start_cnt++; start_cyc = cyc; end
        if (err_last && busy && err_cyc < 0) err_cyc = cyc;
        acc = bus.s_valid && bus.s_ready;
        if (acc) last_acc_cyc = cyc;
        if (acc && bus.s_last && slast_cyc < 0) slast_cyc = cyc;
        acc_prev = acc;
    end

    function automatic logic [15:0] src(input bit w, input int e, input bit ones);
        if (w) return 16'(e * 13) ^ 16'h5A5A;
        return ones ? 16'hFFFF : 16'(e * 7 + 3);
    endfunction

    function automatic logic [31:0] outs();
        return 32'({busy, start, err_last, bus.s_ready, bus.ifm_we, bus.wgt_we,
                    |bus.wr_addr, |bus.wr_data, |bus.wr_mask});
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic run_load(input int isz, input int ich, input int ksz, input int nf,
                            input bit gaps, input int bad_beat, input int rst_beat,
                            input int req_beat, input bit ones, output bit aborted);
        int itot, wtot, ib, wb, b, idx, budget, e;
        bit is_w, want, acc;
        itot = isz * isz * ich;
        wtot = ksz * ksz * ich * nf;
        ib = (itot + 15) / 16;
        wb = (wtot + 15) / 16;
        aborted = 1'b0;
        ifm_size = 9'(isz); ifm_channel = 11'(ich); kernel_size = 2'(ksz); num_filter = 11'(nf);
        load_req = 1'b1;
        @(posedge clk); #1;
        load_req = 1'b0;
        b = 0;
        budget = 0;
        while (b < ib + wb && budget < 20000) begin
            is_w = (b >= ib);
            idx = is_w ? b - ib : b;
            if (is_w && idx == rst_beat) begin
                bus.s_valid = 1'b0; bus.s_last = 1'b0; rst_n = 1'b0;
                @(posedge clk); #1;
                rst_n = 1'b1;
                aborted = 1'b1;
                return;
            end
            want = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.s_valid = want;
            for (int k = 0; k < 16; k++) begin
                e = idx * 16 + k;
                bus.s_data[k*16 +: 16] = (e < (is_w ? wtot : itot)) ? src(is_w, e, ones) : 16'h0;
            end
            bus.s_last = is_w ? (idx == wb - 1) : (idx == bad_beat);
            load_req = (!is_w && idx == req_beat);
            acc = want && bus.s_ready;
            @(posedge clk); #1;
            load_req = 1'b0;
            if (acc) b++;
            budget++;
        end
        bus.s_valid = 1'b0;
        bus.s_last = 1'b0;
        chk("stream_complete", 32'(b), 32'(ib + wb));
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic verify(input string t, input int itot, input int wtot,
                          input int ib, input int ila, input int ilm,
                          input int wb, input int wla, input int wlm,
                          input bit exp_err, input bit ones);
        int bad_i, bad_w;
        bad_i = 0;
        bad_w = 0;
        chk({t, "_ifm_writes"}, ifm_wr, ib);
        chk({t, "_ifm_last_addr"}, ifm_la, ila);
        chk({t, "_ifm_last_mask"}, ifm_lm, ilm);
        chk({t, "_wgt_writes"}, wgt_wr, wb);
        chk({t, "_wgt_last_addr"}, wgt_la, wla);
        chk({t, "_wgt_last_mask"}, wgt_lm, wlm);
        chk({t, "_stray_writes"}, stray, 0);
        chk({t, "_start_count"}, start_cnt, 1);
        chk({t, "_start_latency"}, start_cyc - last_acc_cyc, 2);
        chk({t, "_ready_latency"}, rdy_cyc - req_cyc, 2);
        chk({t, "_err_last"}, 32'(err_last), 32'(exp_err));
        chk({t, "_busy_after"}, 32'(busy), 0);
        for (int i = 0; i < itot; i++) if (ifm_mem[i] !== src(1'b0, i, ones)) bad_i++;
        for (int i = 0; i < wtot; i++) if (wgt_mem[i] !== src(1'b1, i, ones)) bad_w++;
        chk({t, "_ifm_ram_errors"}, bad_i, 0);
        chk({t, "_wgt_ram_errors"}, bad_w, 0);
    endtask

    initial begin
        bit ab;
        bus.s_valid = 1'b0;
        bus.s_data = '0;
        bus.s_last = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", outs(), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_load(15, 16, 3, 32, 1'b0, -1, -1, -1, 1'b0, ab);
        verify("cont", 3600, 4608, 225, 3584, 16'hFFFF, 288, 4592, 16'hFFFF, 1'b0, 1'b0);

        run_load(5, 3, 1, 2, 1'b0, -1, -1, -1, 1'b0, ab);
        verify("small", 75, 6, 5, 64, 16'h07FF, 1, 0, 16'h003F, 1'b0, 1'b0);

        run_load(15, 16, 3, 32, 1'b1, -1, -1, -1, 1'b0, ab);
        verify("gaps", 3600, 4608, 225, 3584, 16'hFFFF, 288, 4592, 16'hFFFF, 1'b0, 1'b0);

        run_load(15, 16, 3, 32, 1'b0, 10, -1, -1, 1'b0, ab);
        verify("slast", 3600, 4608, 225, 3584, 16'hFFFF, 288, 4592, 16'hFFFF, 1'b1, 1'b0);
        chk("slast_err_timing", err_cyc - slast_cyc, 1);

        run_load(15, 16, 3, 32, 1'b0, -1, 100, -1, 1'b0, ab);
        chk("abort_taken", 32'(ab), 1);
        chk("abort_outputs", outs(), 0);
        @(posedge clk); #1;

        run_load(15, 16, 3, 32, 1'b0, -1, -1, 20, 1'b0, ab);
        verify("reload", 3600, 4608, 225, 3584, 16'hFFFF, 288, 4592, 16'hFFFF, 1'b0, 1'b0);

`ifdef LAYER_LOADER_CHECKSUM_EN
        begin
            logic [15:0] wsum;
            wsum = '0;
            for (int i = 0; i < 6; i++) wsum = wsum + src(1'b1, i, 1'b1);
            run_load(5, 3, 1, 2, 1'b0, -1, -1, -1, 1'b1, ab);
            chk("ifm_checksum", 32'(ifm_checksum), 32'h0000FFB5);
            chk("wgt_checksum", 32'(wgt_checksum), 32'(wsum));
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/layer_loader.md
Name: layer_loader

Overview:
- Host-side writer that fills the accelerator's IFM and weight dual-port RAMs from a streamed INOUT_WIDTH-bit host bus, replacing backdoor preloading of those RAMs.
- Sequence: IFM region, then weight region, each packed INOUT_WIDTH/DATA_WIDTH elements per beat, then a one-cycle start pulse to the top-level controller.
- Sits between the host interface and the write ports of the IFM/WGT dpram instances; the layer-config inputs are shared with the main control.

Parameters:
- DATA_WIDTH, 16, element width in bits.
- INOUT_WIDTH, 256, host beat width; LANES = INOUT_WIDTH/DATA_WIDTH = 16.
- ADDR_WIDTH, 24, element address width (covers WGT_RAM_SIZE 8845488).

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- load_req  in  1  one-cycle request to start a load.
- ifm_size  in  9  IFM height = width.
- ifm_channel  in  11  IFM channels.
- kernel_size  in  2  kernel height = width.
- num_filter  in  11  filter count.
- s_valid  in  1  host beat valid.
- s_data  in  INOUT_WIDTH  host beat; lane k in bits [16k+15:16k], lane 0 = lowest address.
- s_last  in  1  host marks final weight beat.
- s_ready  out  1  loader accepts beat.
- ifm_we  out  1  IFM RAM write strobe.
- wgt_we  out  1  WGT RAM write strobe.
- wr_addr  out  ADDR_WIDTH  element address of lane 0.
- wr_data  out  INOUT_WIDTH  write data.
- wr_mask  out  LANES  per-lane write enable.
- busy  out  1  load in progress.
- start  out  1  one-cycle pulse to the top-level controller.
- err_last  out  1  sticky s_last protocol error.

Behaviour:
- Reset: every output is 0; state IDLE; counters 0. Reset mid-load aborts immediately with no further writes; err_last clears.
- FSM states: IDLE, CALC, LOAD_IFM, LOAD_WGT, DONE.
- IDLE: a load_req goes to CALC and clears err_last. load_req in any other state is ignored.
- CALC (1 cycle):
  - Register ifm_total = ifm_size^2 * ifm_channel.
  - Register wgt_total = kernel_size^2 * ifm_channel * num_filter.
  - Registers are 32 bits; all products are unsigned with no truncation.
  - If ifm_total==0, skip to LOAD_WGT. If wgt_total==0 too, go to DONE.
- LOAD_IFM / LOAD_WGT:
  - s_ready=1; a beat is accepted when s_valid && s_ready.
  - Write is registered: a beat accepted at cycle n drives we/wr_addr/wr_data/wr_mask at n+1 for exactly 1 cycle.
  - wr_addr starts at 0 in each region and increments by LANES per beat.
  - wr_mask = all ones, except on the final beat of a region. There, only the lanes with remaining elements are set, low lanes first: remaining = total - beats*LANES.
  - After the final IFM beat, go to LOAD_WGT. The weight region always starts at a new beat and address 0.
  - After the final WGT beat, go to DONE.
- s_valid low: hold state; no write.
- s_last check:
  - s_last on any accepted beat other than the final WGT beat sets err_last.
  - s_last absent on the final WGT beat also sets err_last.
  - The load continues by count in both cases.
- DONE (1 cycle): start=1, s_ready=0, then IDLE.
- busy=1 from CALC through DONE inclusive. s_ready=0 in IDLE, CALC and DONE.
- Throughput: 1 beat/cycle sustained.
- Latency: load_req to first s_ready = 2 cycles; last beat accepted to start = 2 cycles.

Optional Feature:
- Macro LAYER_LOADER_CHECKSUM_EN.
- When defined:
  - Extra outputs ifm_checksum[15:0] and wgt_checksum[15:0].
  - Each is the mod-2^16 sum of every masked-in element written to its region.
  - Cleared in CALC; stable from start pulse until the next CALC.
- When undefined: ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- Cfg 15/16/3/32, continuous s_valid. Expect:
  - 225 IFM beats, last wr_mask=0xFFFF (3600 elements).
  - 288 WGT beats (4608 elements), last wr_addr=4592.
  - start exactly 2 cycles after the s_last beat; err_last=0.
  - Readback of both RAMs matches the source files.
- Cfg ifm_size=5, ifm_channel=3, kernel_size=1, num_filter=2. Expect:
  - ifm_total=75 gives 5 beats; final wr_addr=64, wr_mask=0x07FF.
  - wgt_total=6 gives 1 beat, wr_mask=0x003F.
- Random s_valid gaps (50%) on the first config: identical write sequence and RAM contents; no write in gap cycles.
- s_last asserted on IFM beat 10: err_last=1 from the following cycle; the load still completes with start pulse and correct contents.
- rst_n low for 1 cycle during WGT beat 100: all outputs 0 next cycle; a subsequent load_req reloads correctly. load_req pulsed while busy has no effect.
- With LAYER_LOADER_CHECKSUM_EN: all-ones IFM data for the 5/3 config gives ifm_checksum=0xFFB5 (75 * 0xFFFF mod 2^16).
